// File: rtl/hwpe_kernel_flags_pkg.sv
// Shared types and constants for the HWPE kernel flag controller.
package hwpe_kernel_flags_pkg;

   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned MAX_CH    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef logic [MAX_CH-1:0][CNT_W_DEF-1:0] limit_arr_t;

endpackage

// File: rtl/hwpe_beat_counter.sv
// Per-channel beat counter: load on job start, count up to the limit, then hold and flag excess beats.
module hwpe_beat_counter
   import hwpe_kernel_flags_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hs,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             complete_nxt,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] lim_sel;
   logic             ovf_r;
   logic             ovf_nxt;

   // Next count/overflow; a zero limit means the channel is ignored (no counting, no flag).
   always_comb begin
      count_nxt = count_r;
      ovf_nxt   = ovf_r;
      lim_sel   = limit;
      if (clear) begin
         count_nxt = ZERO;
         ovf_nxt   = 1'b0;
         lim_sel   = ZERO;
      end else if (load) begin
         count_nxt = (hs && (load_val != ZERO)) ? ONE : ZERO;
         ovf_nxt   = 1'b0;
         lim_sel   = load_val;
      end else if (en && hs && (limit != ZERO)) begin
         if (count_r != limit) begin
            count_nxt = count_r + ONE;
         end else begin
            ovf_nxt = 1'b1;
         end
      end else begin
         count_nxt = count_r;
      end
      complete_nxt = (count_nxt == lim_sel);
   end

   // Counter and sticky overflow registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= ZERO;
         ovf_r   <= 1'b0;
      end else begin
         count_r <= count_nxt;
         ovf_r   <= ovf_nxt;
      end
   end

   assign count    = count_r;
   assign overflow = ovf_r;

endmodule

// File: rtl/hwpe_kernel_flags_ctrl.sv
// ap_ctrl-style ready/done/idle generation from tapped stream handshakes with per-channel beat limits.
module hwpe_kernel_flags_ctrl
   import hwpe_kernel_flags_pkg::*;
#(
   parameter int unsigned N_IN  = 2,
   parameter int unsigned N_OUT = 1,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    start_i,
   input  logic [N_IN-1:0]         in_hs_i,
   input  logic [N_OUT-1:0]        out_hs_i,
   input  logic [N_IN*CNT_W-1:0]   in_max_i,
   input  logic [N_OUT*CNT_W-1:0]  out_max_i,
   output logic                    ready_o,
   output logic                    done_o,
   output logic                    idle_o,
   output logic [N_IN*CNT_W-1:0]   cnt_in_o,
   output logic [N_OUT*CNT_W-1:0]  cnt_out_o,
   output logic [N_IN+N_OUT-1:0]   overflow_o
);

   state_t                         state_r;
   state_t                         state_nxt;
   logic                           load;
   logic                           run_en;
   logic                           ready_r;
   logic [N_IN-1:0][CNT_W-1:0]     in_lim_r;
   logic [N_OUT-1:0][CNT_W-1:0]    out_lim_r;
   logic [N_IN-1:0]                in_cmp_nxt;
   logic [N_OUT-1:0]               out_cmp_nxt;
   logic                           all_out_nxt;

   // A start is only accepted outside RUN, and clear always wins.
   assign load        = start_i & ~clear_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
   assign run_en      = (state_r == ST_RUN) | (state_r == ST_DONE);
   assign all_out_nxt = &out_cmp_nxt;

   // Next-state logic; completion is judged on post-edge counts so done_o follows the last beat by one cycle.
   always_comb begin
      state_nxt = state_r;
      if (clear_i) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (load) begin
                  state_nxt = all_out_nxt ? ST_DONE : ST_RUN;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (all_out_nxt) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
            ST_DONE: begin
               if (load) begin
                  state_nxt = all_out_nxt ? ST_DONE : ST_RUN;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and ready registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_nxt;
         ready_r <= ~clear_i & (state_nxt != ST_IDLE) & (&in_cmp_nxt);
      end
   end

   // Job limits, captured only when a start is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_lim_r  <= {(N_IN*CNT_W){1'b0}};
         out_lim_r <= {(N_OUT*CNT_W){1'b0}};
      end else if (clear_i) begin
         in_lim_r  <= {(N_IN*CNT_W){1'b0}};
         out_lim_r <= {(N_OUT*CNT_W){1'b0}};
      end else if (load) begin
         in_lim_r  <= in_max_i;
         out_lim_r <= out_max_i;
      end else begin
         in_lim_r  <= in_lim_r;
         out_lim_r <= out_lim_r;
      end
   end

   for (genvar i = 0; i < N_IN; i++) begin : g_in
      hwpe_beat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk          (clk_i),
         .rst          (rst_i),
         .clear        (clear_i),
         .en           (run_en),
         .load         (load),
         .load_val     (in_max_i[i*CNT_W +: CNT_W]),
         .hs           (in_hs_i[i]),
         .limit        (in_lim_r[i]),
         .count        (cnt_in_o[i*CNT_W +: CNT_W]),
         .complete_nxt (in_cmp_nxt[i]),
         .overflow     (overflow_o[i])
      );
   end

   for (genvar j = 0; j < N_OUT; j++) begin : g_out
      hwpe_beat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk          (clk_i),
         .rst          (rst_i),
         .clear        (clear_i),
         .en           (run_en),
         .load         (load),
         .load_val     (out_max_i[j*CNT_W +: CNT_W]),
         .hs           (out_hs_i[j]),
         .limit        (out_lim_r[j]),
         .count        (cnt_out_o[j*CNT_W +: CNT_W]),
         .complete_nxt (out_cmp_nxt[j]),
         .overflow     (overflow_o[N_IN+j])
      );
   end

   assign ready_o = ready_r;
   assign done_o  = (state_r == ST_DONE);
   assign idle_o  = (state_r == ST_IDLE);

endmodule

// File: tb/tb_hwpe_kernel_flags_ctrl.sv
// Directed + random bench for hwpe_kernel_flags_ctrl against a job-level behavioural model.
module tb_hwpe_kernel_flags_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        start;
   logic [1:0]  in_hs;
   logic [0:0]  out_hs;
   logic [31:0] in_max;
   logic [15:0] out_max;
   logic        ready;
   logic        done;
   logic        idle;
   logic [31:0] cnt_in;
   logic [15:0] cnt_out;
   logic [2:0]  ovf;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: channels 0,1 are inputs, 2 is the output.
   int m_cnt [3];
   int m_lim [3];
   bit m_ovf [3];
   bit m_busy;
   bit m_done;

   hwpe_kernel_flags_ctrl #(.N_IN(2), .N_OUT(1), .CNT_W(16)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clear_i    (clear),
      .start_i    (start),
      .in_hs_i    (in_hs),
      .out_hs_i   (out_hs),
      .in_max_i   (in_max),
      .out_max_i  (out_max),
      .ready_o    (ready),
      .done_o     (done),
      .idle_o     (idle),
      .cnt_in_o   (cnt_in),
      .cnt_out_o  (cnt_out),
      .overflow_o (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         m_cnt[c] = 0;
         m_lim[c] = 0;
         m_ovf[c] = 1'b0;
      end
      m_busy = 1'b0;
      m_done = 1'b0;
   endtask

   // One clock of the job-level rules: start from idle/done latches limits, beats count up to the limit.
   task automatic model_step(input bit st, input bit cl, input logic [1:0] ih, input logic oh);
      bit hs [3];
      hs[0] = ih[0];
      hs[1] = ih[1];
      hs[2] = oh;
      if (cl) begin
         model_reset();
      end else if (st && (!m_busy || m_done)) begin
         m_lim[0] = int'(in_max[15:0]);
         m_lim[1] = int'(in_max[31:16]);
         m_lim[2] = int'(out_max);
         for (int c = 0; c < 3; c++) begin
            m_cnt[c] = (hs[c] && m_lim[c] != 0) ? 1 : 0;
            m_ovf[c] = 1'b0;
         end
         m_busy = 1'b1;
         m_done = (m_cnt[2] == m_lim[2]);
      end else if (m_busy) begin
         for (int c = 0; c < 3; c++) begin
            if (hs[c] && m_lim[c] != 0) begin
               if (m_cnt[c] < m_lim[c]) m_cnt[c]++;
               else m_ovf[c] = 1'b1;
            end
         end
         if (m_done) begin
            m_busy = 1'b0;
            m_done = 1'b0;
         end else begin
            m_done = (m_cnt[2] == m_lim[2]);
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".idle"},   {31'd0, idle},  {31'd0, !m_busy});
      chk({tag, ".done"},   {31'd0, done},  {31'd0, m_done});
      chk({tag, ".ready"},  {31'd0, ready},
          {31'd0, m_busy && (m_cnt[0] == m_lim[0]) && (m_cnt[1] == m_lim[1])});
      chk({tag, ".cnt_in0"}, {16'd0, cnt_in[15:0]},  m_cnt[0]);
      chk({tag, ".cnt_in1"}, {16'd0, cnt_in[31:16]}, m_cnt[1]);
      chk({tag, ".cnt_out"}, {16'd0, cnt_out},       m_cnt[2]);
      chk({tag, ".ovf"},     {29'd0, ovf},           {29'd0, m_ovf[2], m_ovf[1], m_ovf[0]});
   endtask

   task automatic cycle(input string tag, input bit st, input bit cl, input logic [1:0] ih, input logic oh);
      @(negedge clk);
      start  = st;
      clear  = cl;
      in_hs  = ih;
      out_hs = oh;
      model_step(st, cl, ih, oh);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst     = 1'b1;
      clear   = 1'b0;
      start   = 1'b0;
      in_hs   = 2'b00;
      out_hs  = 1'b0;
      in_max  = 32'd0;
      out_max = 16'd0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Job 1: {4,4} inputs, 1 output; channel 1 slower than channel 0.
      in_max = {16'd4, 16'd4}; out_max = 16'd1;
      cycle("t1_start", 1'b1, 1'b0, 2'b00, 1'b0);
      cycle("t1_b1", 1'b0, 1'b0, 2'b11, 1'b0);
      cycle("t1_b2", 1'b0, 1'b0, 2'b01, 1'b0);
      cycle("t1_b3", 1'b0, 1'b0, 2'b11, 1'b0);
      cycle("t1_b4", 1'b0, 1'b0, 2'b01, 1'b0);
      cycle("t1_b5", 1'b0, 1'b0, 2'b10, 1'b0);
      cycle("t1_b6", 1'b0, 1'b0, 2'b10, 1'b0);
      chk("t1_ready_direct", {31'd0, ready}, 32'd1);
      cycle("t1_out", 1'b0, 1'b0, 2'b00, 1'b1);
      chk("t1_done_lat", {31'd0, done}, 32'd1);
      cycle("t1_idle", 1'b0, 1'b0, 2'b00, 1'b0);
      chk("t1_idle_lat", {31'd0, idle}, 32'd1);

      // Job 2: channel 1 disabled (its beats are ignored), two output beats.
      in_max = {16'd0, 16'd3}; out_max = 16'd2;
      cycle("t2_start", 1'b1, 1'b0, 2'b00, 1'b0);
      for (int k = 0; k < 3; k++) cycle("t2_in", 1'b0, 1'b0, 2'b11, 1'b0);
      cycle("t2_o1", 1'b0, 1'b0, 2'b00, 1'b1);
      cycle("t2_o2", 1'b0, 1'b0, 2'b00, 1'b1);
      cycle("t2_idle", 1'b0, 1'b0, 2'b00, 1'b0);

      // Job 3: three output beats against a limit of 2 -> saturate and flag.
      in_max = {16'd0, 16'd0}; out_max = 16'd2;
      cycle("t3_start", 1'b1, 1'b0, 2'b00, 1'b0);
      for (int k = 0; k < 3; k++) cycle("t3_out", 1'b0, 1'b0, 2'b00, 1'b1);
      chk("t3_cnt_hold", {16'd0, cnt_out}, 32'd2);
      chk("t3_ovf", {29'd0, ovf}, 32'd4);
      cycle("t3_quiet", 1'b0, 1'b0, 2'b00, 1'b0);

      // Job 4: back-to-back restart in the DONE cycle with new limits.
      in_max = {16'd2, 16'd2}; out_max = 16'd1;
      cycle("t4_start", 1'b1, 1'b0, 2'b00, 1'b0);
      cycle("t4_in1", 1'b0, 1'b0, 2'b11, 1'b0);
      cycle("t4_in2", 1'b0, 1'b0, 2'b11, 1'b0);
      cycle("t4_out", 1'b0, 1'b0, 2'b00, 1'b1);
      in_max = {16'd1, 16'd1};
      cycle("t4_restart", 1'b1, 1'b0, 2'b00, 1'b0);
      chk("t4_no_idle", {31'd0, idle}, 32'd0);
      cycle("t4_in", 1'b0, 1'b0, 2'b11, 1'b0);
      cycle("t4_out2", 1'b0, 1'b0, 2'b00, 1'b1);
      cycle("t4_end", 1'b0, 1'b0, 2'b00, 1'b0);

      // Job 5: clear mid-run, then a normal job.
      in_max = {16'd4, 16'd4}; out_max = 16'd1;
      cycle("t5_start", 1'b1, 1'b0, 2'b00, 1'b0);
      cycle("t5_b1", 1'b0, 1'b0, 2'b01, 1'b0);
      cycle("t5_b2", 1'b0, 1'b0, 2'b01, 1'b0);
      cycle("t5_clear", 1'b1, 1'b1, 2'b01, 1'b1);
      in_max = {16'd1, 16'd1};
      cycle("t5_restart", 1'b1, 1'b0, 2'b11, 1'b0);
      cycle("t5_out", 1'b0, 1'b0, 2'b00, 1'b1);
      cycle("t5_end", 1'b0, 1'b0, 2'b00, 1'b0);

      // Job 6: beat coincident with start counts; all outputs disabled -> done next cycle.
      in_max = {16'd3, 16'd3}; out_max = 16'd0;
      cycle("t6_start", 1'b1, 1'b0, 2'b01, 1'b0);
      chk("t6_cnt0", {16'd0, cnt_in[15:0]}, 32'd1);
      chk("t6_done", {31'd0, done}, 32'd1);
      cycle("t6_end", 1'b0, 1'b0, 2'b00, 1'b0);

      // Job 7: asynchronous reset mid-run.
      in_max = {16'd5, 16'd5}; out_max = 16'd3;
      cycle("t7_start", 1'b1, 1'b0, 2'b11, 1'b0);
      cycle("t7_b", 1'b0, 1'b0, 2'b11, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("t7_async_rst");
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      clear = 1'b0;

      // Random traffic; limits wander every cycle to confirm they are only captured at start.
      for (int n = 0; n < 400; n++) begin
         bit st;
         bit cl;
         st      = ($urandom_range(0, 5) == 0);
         cl      = ($urandom_range(0, 49) == 0);
         in_max  = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))};
         out_max = 16'($urandom_range(0, 3));
         cycle("rnd", st, cl, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
